// File: rtl/range_stream_tx.sv
// Buffered go/finish frame transmitter feeding the range finder.
// Define RANGE_TX_EXPECT_EN to also produce expected_range (max-min of each frame).
module range_stream_tx #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       start,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       done,
  output logic                       start_err,
  output logic                       go,
  output logic                       finish,
  output logic [WIDTH-1:0]           data_out,
  output logic [WIDTH-1:0]           expected_range
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, left_q, left_nxt;
  logic             push, pop;
  logic             go_nxt, fin_nxt;
  logic             done_nxt, err_nxt;
  logic [WIDTH-1:0] dout_nxt;

  // Full is judged on the pre-edge count, so a pop never frees a slot early.
  assign push  = wr_en && (count_q < CW'(DEPTH));
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign busy  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    left_nxt  = left_q;
    pop       = 1'b0;
    go_nxt    = 1'b0;
    fin_nxt   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    dout_nxt  = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (count_q >= CW'(2)) begin
            state_nxt = SEND;
            left_nxt  = count_q - CW'(1);
            pop       = 1'b1;
            go_nxt    = 1'b1;
            dout_nxt  = mem[rd_ptr];
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      SEND: begin
        if (left_q != '0) begin
          pop      = 1'b1;
          dout_nxt = mem[rd_ptr];
          fin_nxt  = (left_q == CW'(1));
          left_nxt = left_q - CW'(1);
        end else begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      left_q    <= '0;
      go        <= 1'b0;
      finish    <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      data_out  <= '0;
    end else begin
      state     <= state_nxt;
      left_q    <= left_nxt;
      count_q   <= count_q + CW'(push) - CW'(pop);
      go        <= go_nxt;
      finish    <= fin_nxt;
      done      <= done_nxt;
      start_err <= err_nxt;
      data_out  <= dout_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

`ifdef RANGE_TX_EXPECT_EN
  logic [WIDTH-1:0] min_q, max_q;

  // First pop of a frame seeds min/max; done publishes their difference.
  always_ff @(posedge clock) begin
    if (!reset) begin
      min_q          <= '0;
      max_q          <= '0;
      expected_range <= '0;
    end else begin
      if (pop) begin
        if (state == IDLE) begin
          min_q <= dout_nxt;
          max_q <= dout_nxt;
        end else begin
          if (dout_nxt < min_q) min_q <= dout_nxt;
          if (dout_nxt > max_q) max_q <= dout_nxt;
        end
      end
      if (done_nxt) expected_range <= max_q - min_q;
    end
  end
`else
  assign expected_range = '0;
`endif

endmodule

// File: tb/tb_range_stream_tx.sv
// Bench for range_stream_tx: directed frames plus random traffic
// compared cycle by cycle against a queue-based frame model.
module tb_range_stream_tx;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clock = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             full;
  logic [CW-1:0]    count;
  logic             busy;
  logic             done;
  logic             start_err;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] expected_range;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  range_stream_tx #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .start          (start),
    .full           (full),
    .count          (count),
    .busy           (busy),
    .done           (done),
    .start_err      (start_err),
    .go             (go),
    .finish         (finish),
    .data_out       (data_out),
    .expected_range (expected_range)
  );

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] frame[$];
  int               phase = 0;
  int               n_frame = 0;
  logic             m_go, m_fin, m_done, m_err;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] m_range = '0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] frame_range();
    logic [WIDTH-1:0] lo, hi;
    lo = frame[0];
    hi = frame[0];
    foreach (frame[i]) begin
      if (frame[i] < lo) lo = frame[i];
      if (frame[i] > hi) hi = frame[i];
    end
    return hi - lo;
  endfunction

  task automatic emit();
    m_data = q.pop_front();
    m_go   = (frame.size() == 0);
    frame.push_back(m_data);
    m_fin  = (frame.size() == n_frame);
  endtask

  // What the next clock edge should produce, given the inputs now driven.
  task automatic model_step();
    bit pushed;
    m_go   = 1'b0;
    m_fin  = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_data = '0;
    if (!reset) begin
      q.delete();
      frame.delete();
      phase   = 0;
      m_range = '0;
      return;
    end
    pushed = wr_en && (q.size() < DEPTH);
    case (phase)
      0: if (start) begin
        if (q.size() >= 2) begin
          n_frame = q.size();
          frame.delete();
          phase = 1;
          emit();
        end else begin
          m_err = 1'b1;
        end
      end
      1: if (frame.size() < n_frame) begin
        emit();
      end else begin
        m_done = 1'b1;
        phase  = 2;
`ifdef RANGE_TX_EXPECT_EN
        m_range = frame_range();
`endif
      end
      default: phase = 0;
    endcase
    if (pushed) q.push_back(wr_data);
  endtask

  task automatic cycle(input logic r, input logic we,
                       input logic [WIDTH-1:0] d, input logic st);
    reset   = r;
    wr_en   = we;
    wr_data = d;
    start   = st;
    model_step();
    @(posedge clock);
    @(negedge clock);
    check_eq("data_out", 32'(data_out), 32'(m_data));
    check_eq("go", 32'(go), 32'(m_go));
    check_eq("finish", 32'(finish), 32'(m_fin));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("start_err", 32'(start_err), 32'(m_err));
    check_eq("busy", 32'(busy), 32'(phase != 0));
    check_eq("count", 32'(count), 32'(q.size()));
    check_eq("full", 32'(full), 32'(q.size() == DEPTH));
    check_eq("expected_range", 32'(expected_range), 32'(m_range));
  endtask

  task automatic idle(int n);
    repeat (n) cycle(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(logic [WIDTH-1:0] d);
    cycle(1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic kick();
    cycle(1'b1, 1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    start   = 1'b0;
    do_reset();

    wr(16'd5); wr(16'd9); wr(16'd2); wr(16'd7);
    kick();
    idle(6);

    wr(16'd42);
    kick();
    idle(2);
    do_reset();
    kick();
    idle(2);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH + 1; i++) wr(16'(100 * k + i + 1));
      kick();
      idle(DEPTH + 3);
    end

    wr(16'd11); wr(16'd22); wr(16'd33);
    kick();
    wr(16'd44); wr(16'd55);
    idle(4);
    kick();
    idle(4);

    wr(16'd1); wr(16'd2); wr(16'd3); wr(16'd4);
    kick();
    idle(1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    idle(4);

    wr(16'h0000); wr(16'hFFFF);
    kick();
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      logic             r, we, st;
      logic [WIDTH-1:0] d;
      r  = ($urandom_range(199) != 0);
      we = 1'($urandom_range(1));
      st = ($urandom_range(7) == 0);
      if ($urandom_range(3) == 0) d = $urandom_range(1) ? 16'hFFFF : 16'h0000;
      else d = 16'($urandom);
      cycle(r, we, d, st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
